dcache_controller: RTL
======================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the MEM pipeline stage (p1 side) and the 256-bit external DRAM (mem side).
- Serves 32-bit loads and stores from the pipeline and stalls the pipeline on a miss.
- On a miss it writes back a dirty victim line, then refills the full 256-bit line from DRAM using the enable/ack handshake.

Parameters:
- NUM_LINES, 32, number of cache lines (index width 5).
- LINE_WIDTH, 256, line size in bits (32 bytes, offset width 5).
- WORD_WIDTH, 32, pipeline data width.
- Only the default values are supported and verified.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock, asynchronous, active-high.
- p1_addr_i  in  32  byte address from MEM stage.
- p1_data_i  in  32  store data.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request.
- p1_data_o  out  32  load data.
- p1_stall_o  out  1  pipeline stall.
- mem_data_i  in  256  refill line from DRAM.
- mem_ack_i  in  1  DRAM completion pulse, one cycle.
- mem_data_o  out  256  write-back line.
- mem_addr_o  out  32  line address; bits [4:0] always 0.
- mem_enable_o  out  1  DRAM chip select.
- mem_write_o  out  1  DRAM write enable.

Behaviour:
- Address split: tag = addr[31:10] (22 b), index = addr[9:5], word = addr[4:2], addr[1:0] ignored.
- Word k of a line occupies bits [32k+31:32k].
- Storage uses internal instances dcache_tag_sram (32 x 24 b, {valid, dirty, tag}) and dcache_data_sram (32 x 256 b), each holding an array named memory. Benches probe these, plus reg state and wire sram_dirty (dirty bit of the indexed line).
- hit = valid & (stored tag == tag).
- req = p1_MemRead_i | p1_MemWrite_i. If both are high, the store wins.
- p1_data_o is combinational: always the selected word of the indexed line.
- p1_stall_o = req & ~(state==IDLE & hit). It is combinational and never high without req.
- Pipeline contract: addr, data and request bits are held stable while p1_stall_o=1.

State machine (state encoding: IDLE=0, MISS=1, WRITEBACK=2, READMISS=3, READMISSOK=4):
- IDLE, req & hit & store: at the clock edge, write the word into the line and set dirty=1. No DRAM traffic.
- IDLE, req & hit & load: zero-cycle response, no state change.
- IDLE, req & ~hit: go to MISS.
- MISS, sram_dirty=1: register mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag, index, 5'b0}, mem_data_o=line; go to WRITEBACK.
- MISS, sram_dirty=0: register mem_enable_o=1, mem_write_o=0, mem_addr_o={tag, index, 5'b0}; go to READMISS.
- WRITEBACK, on mem_ack_i: mem_write_o=0, mem_addr_o={new tag, index, 0}; mem_enable_o stays 1; go to READMISS. Otherwise hold.
- READMISS, on mem_ack_i: drop mem_enable_o, write mem_data_i into the line, set tag to {valid=1, dirty=0, tag}; go to READMISSOK. Otherwise hold.
- READMISSOK: go to IDLE. The next IDLE cycle hits; a store miss then completes there as a hit (write-allocate).
- mem_* outputs are registered and held constant while waiting for ack.

Latency, with DRAM acking in the Nth cycle of enable:
- Clean miss: stall for N+3 cycles.
- Dirty miss: stall for 2N+3 cycles.

Reset:
- state=IDLE; mem_enable_o, mem_write_o, mem_addr_o, mem_data_o = 0.
- All tag entries cleared (valid=0, dirty=0). Data SRAM is not cleared.
- Reset mid-miss: abort immediately (asynchronous); enable drops and the partial refill is not installed. A later ack is ignored because the controller is in IDLE.
- An ack in IDLE or MISS is ignored.

Test Plan:
- DRAM line 0 = 256'h5, ack on 10th enable cycle, after reset: load 0x0 -> stall 13 cycles; mem_addr_o=0x0, mem_write_o=0; then p1_data_o=0x5 and stall drops.
- Repeat load 0x0 -> hit, stall=0 same cycle, p1_data_o=0x5, mem_enable_o stays 0.
- Store 0xDEADBEEF to 0x4 (hit) -> no DRAM traffic; tag entry 0 dirty=1; load 0x4 returns 0xDEADBEEF with no stall.
- Load 0x400 (index 0, tag 1, victim dirty):
  - Write-back at 0x0 with mem_data_o[63:32]=DEADBEEF and [31:0]=5.
  - Then refill from 0x400; stall 23 cycles; line valid, dirty=0, tag=1.
- Store 0x12345678 to 0x24 (index 1, invalid) -> refill from 0x20, stall 13 cycles; line 1 word1 = 0x12345678, dirty=1.
- Assert rst_i during READMISS -> mem_enable_o=0 and state=0 immediately, entry invalid; repeating the load refetches (full 13-cycle stall).

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Tag/data SRAMs are local modules; DRAM side uses an enable/ack handshake.

module dcache_tag_sram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] memory [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) memory[i] <= '0;
    end else if (we) begin
      memory[addr] <= wdata;
    end
  end

  assign rdata = memory[addr];
endmodule

module dcache_data_sram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 256
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

module dcache_controller #(
  parameter int unsigned NUM_LINES  = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           p1_addr_i,
  input  logic [WORD_WIDTH-1:0] p1_data_i,
  input  logic                  p1_MemRead_i,
  input  logic                  p1_MemWrite_i,
  output logic [WORD_WIDTH-1:0] p1_data_o,
  output logic                  p1_stall_o,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic [LINE_WIDTH-1:0] mem_data_o,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    READMISS   = 3'd3,
    READMISSOK = 3'd4
  } state_t;

  state_t state, state_next;

  logic [21:0] addr_tag;
  logic [4:0]  index;
  logic [2:0]  word_sel;
  logic        unused_addr_bits;

  assign addr_tag         = p1_addr_i[31:10];
  assign index            = p1_addr_i[9:5];
  assign word_sel         = p1_addr_i[4:2];
  assign unused_addr_bits = &{1'b0, p1_addr_i[1:0]};

  logic [23:0]           tag_rdata, tag_wdata;
  logic [LINE_WIDTH-1:0] line, line_wr, data_wdata;
  logic                  tag_we, data_we;
  logic                  sram_valid, sram_dirty, hit, req;
  logic [21:0]           sram_tag;

  dcache_tag_sram #(.DEPTH(NUM_LINES), .WIDTH(24)) dcache_tag_sram (
    .clk(clk_i), .rst(rst_i), .addr(index), .we(tag_we),
    .wdata(tag_wdata), .rdata(tag_rdata)
  );

  dcache_data_sram #(.DEPTH(NUM_LINES), .WIDTH(LINE_WIDTH)) dcache_data_sram (
    .clk(clk_i), .addr(index), .we(data_we),
    .wdata(data_wdata), .rdata(line)
  );

  assign sram_valid = tag_rdata[23];
  assign sram_dirty = tag_rdata[22];
  assign sram_tag   = tag_rdata[21:0];
  assign hit        = sram_valid && (sram_tag == addr_tag);
  assign req        = p1_MemRead_i || p1_MemWrite_i;
  assign p1_stall_o = req && !(state == IDLE && hit);
  assign p1_data_o  = line[{word_sel, 5'b0} +: WORD_WIDTH];

  always_comb begin
    line_wr = line;
    line_wr[{word_sel, 5'b0} +: WORD_WIDTH] = p1_data_i;
  end

  // A store hit and a refill install are the only two SRAM writers and never coincide.
  logic store_hit, refill;
  assign store_hit  = (state == IDLE) && req && hit && p1_MemWrite_i;
  assign refill     = (state == READMISS) && mem_ack_i;
  assign tag_we     = store_hit || refill;
  assign data_we    = store_hit || refill;
  assign tag_wdata  = refill ? {1'b1, 1'b0, addr_tag} : {1'b1, 1'b1, sram_tag};
  assign data_wdata = refill ? mem_data_i : line_wr;

  logic                  enable_next, write_next;
  logic [31:0]           maddr_next;
  logic [LINE_WIDTH-1:0] mdata_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state        <= state_next;
      mem_enable_o <= enable_next;
      mem_write_o  <= write_next;
      mem_addr_o   <= maddr_next;
      mem_data_o   <= mdata_next;
    end
  end

  always_comb begin
    state_next  = state;
    enable_next = mem_enable_o;
    write_next  = mem_write_o;
    maddr_next  = mem_addr_o;
    mdata_next  = mem_data_o;
    case (state)
      IDLE: if (req && !hit) state_next = MISS;
      MISS: begin
        enable_next = 1'b1;
        if (sram_dirty) begin
          write_next = 1'b1;
          maddr_next = {sram_tag, index, 5'b0};
          mdata_next = line;
          state_next = WRITEBACK;
        end else begin
          write_next = 1'b0;
          maddr_next = {addr_tag, index, 5'b0};
          state_next = READMISS;
        end
      end
      WRITEBACK: if (mem_ack_i) begin
        write_next = 1'b0;
        maddr_next = {addr_tag, index, 5'b0};
        state_next = READMISS;
      end
      READMISS: if (mem_ack_i) begin
        enable_next = 1'b0;
        state_next  = READMISSOK;
      end
      READMISSOK: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end
endmodule
